// File: rtl/d_trig_pipe_pkg.sv
// d_trig_pipe_pkg: shared constants and helpers for the d_trig_pipe delay line.
//   clog2          - ceiling log2, used to size the LEVEL counter (clog2(DEPTH+1))
//   DEF_*          - default WIDTH / DEPTH / INIT_VAL
//   lvl_op_e       - LEVEL counter update encoding (hold / increment / decrement)
package d_trig_pipe_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_INIT_VAL = 32'h0;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  // Smallest r with 2**r >= n; returns at least 1 so a counter never collapses to zero width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/d_trig_pipe_if.sv
// d_trig_pipe_if: bus bundle for d_trig_pipe.
//   master modport (producer/consumer side): drives CE, D, DV, FLUSH; observes outputs.
//   slave  modport (the pipe):               receives CE, D, DV, FLUSH; drives
//     Q, notQ, QV, LEVEL, FULL, EMPTY (and QH, QHV when D_TRIG_PIPE_HOLD_EN is defined).
// Optional macro: D_TRIG_PIPE_HOLD_EN adds the QH/QHV hold outputs.
interface d_trig_pipe_if
  import d_trig_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned LW = clog2(DEPTH + 1);

  logic             CE;
  logic [WIDTH-1:0] D;
  logic             DV;
  logic             FLUSH;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] notQ;
  logic             QV;
  logic [LW-1:0]    LEVEL;
  logic             FULL;
  logic             EMPTY;
`ifdef D_TRIG_PIPE_HOLD_EN
  logic [WIDTH-1:0] QH;
  logic             QHV;

  modport master (output CE, D, DV, FLUSH,
                  input  Q, notQ, QV, LEVEL, FULL, EMPTY, QH, QHV);
  modport slave  (input  CE, D, DV, FLUSH,
                  output Q, notQ, QV, LEVEL, FULL, EMPTY, QH, QHV);
`else
  modport master (output CE, D, DV, FLUSH,
                  input  Q, notQ, QV, LEVEL, FULL, EMPTY);
  modport slave  (input  CE, D, DV, FLUSH,
                  output Q, notQ, QV, LEVEL, FULL, EMPTY);
`endif

endinterface

// File: rtl/d_trig_stage.sv
// d_trig_stage: one delay-line stage (WIDTH-bit data register + valid bit).
//   clk   - rising-edge clock        rst_n - async active-low reset (q=INIT_VAL, qv=0)
//   ce    - clock enable             flush - clears qv at the edge, data still follows ce
//   d/dv  - stage input              q/qv  - registered stage output
module d_trig_stage
  import d_trig_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(DEF_INIT_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= INIT_VAL;
      qv <= 1'b0;
    end else begin
      if (ce) q <= d;
      if (flush)   qv <= 1'b0;
      else if (ce) qv <= dv;
    end
  end

endmodule

// File: rtl/d_trig_pipe.sv
// d_trig_pipe: WIDTH-bit, DEPTH-stage registered delay line with per-stage valid,
// clock enable, synchronous flush and a registered occupancy counter.
//   C   - rising-edge clock          R   - async active-low reset
//   bus - d_trig_pipe_if.slave: CE, D, DV, FLUSH in; Q, notQ, QV, LEVEL, FULL, EMPTY out
// Optional macro: D_TRIG_PIPE_HOLD_EN adds QH/QHV, a sticky copy of the most recent
// valid word to leave the last stage.
module d_trig_pipe
  import d_trig_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter int unsigned      DEPTH    = DEF_DEPTH,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(DEF_INIT_VAL)
) (
  input logic         C,
  input logic         R,
  d_trig_pipe_if.slave bus
);

  localparam int unsigned LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic             stg_v [DEPTH];
  logic [LW-1:0]    level_q;
  lvl_op_e          lvl_op;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             dv_in;
    if (i == 0) begin : g_head
      assign d_in  = bus.D;
      assign dv_in = bus.DV;
    end else begin : g_tail
      assign d_in  = stg_q[i-1];
      assign dv_in = stg_v[i-1];
    end
    d_trig_stage #(
      .WIDTH    (WIDTH),
      .INIT_VAL (INIT_VAL)
    ) u_stage (
      .clk   (C),
      .rst_n (R),
      .ce    (bus.CE),
      .flush (bus.FLUSH),
      .d     (d_in),
      .dv    (dv_in),
      .q     (stg_q[i]),
      .qv    (stg_v[i])
    );
  end

  // Occupancy changes only when a valid word enters without one leaving, or vice versa;
  // this keeps LEVEL equal to the number of set valid bits without a popcount.
  always_comb begin
    lvl_op = LVL_HOLD;
    if (bus.CE && bus.DV && !stg_v[DEPTH-1])      lvl_op = LVL_INC;
    else if (bus.CE && !bus.DV && stg_v[DEPTH-1]) lvl_op = LVL_DEC;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      level_q <= '0;
    end else if (bus.FLUSH) begin
      level_q <= '0;
    end else begin
      case (lvl_op)
        LVL_INC: level_q <= level_q + LW'(1);
        LVL_DEC: level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.Q     = stg_q[DEPTH-1];
  assign bus.notQ  = ~stg_q[DEPTH-1];
  assign bus.QV    = stg_v[DEPTH-1];
  assign bus.LEVEL = level_q;
  assign bus.FULL  = (level_q == LW'(DEPTH));
  assign bus.EMPTY = (level_q == '0);

`ifdef D_TRIG_PIPE_HOLD_EN
  logic [WIDTH-1:0] qh_q;
  logic             qhv_q;

  // Captures the word as it is shifted out of the last stage; FLUSH does not touch it,
  // and a word leaving on a flushing CE edge is still captured.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      qh_q  <= INIT_VAL;
      qhv_q <= 1'b0;
    end else if (bus.CE && stg_v[DEPTH-1]) begin
      qh_q  <= stg_q[DEPTH-1];
      qhv_q <= 1'b1;
    end
  end

  assign bus.QH  = qh_q;
  assign bus.QHV = qhv_q;
`endif

endmodule

// File: tb/tb_d_trig_pipe.sv
module tb_d_trig_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned DP = 4;
  localparam logic [7:0]  IV = 8'h5A;

  logic C;
  logic R;
  int   total;
  int   bad;

  d_trig_pipe_if #(.WIDTH(W), .DEPTH(DP)) bus ();

  d_trig_pipe #(
    .WIDTH    (W),
    .DEPTH    (DP),
    .INIT_VAL (IV)
  ) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Reference model: the pipe as an array of (data, valid) words, shifted as a whole.
  logic [7:0] md [DP];
  logic       mv [DP];
  logic [7:0] mh;
  logic       mhv;

  function automatic int model_level();
    int n;
    n = 0;
    for (int i = 0; i < DP; i++) n += int'(mv[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) begin
      md[i] = IV;
      mv[i] = 1'b0;
    end
    mh  = IV;
    mhv = 1'b0;
  endtask

  task automatic model_edge(input bit ce, input logic [7:0] d, input bit dv, input bit fl);
    if (ce) begin
      if (mv[DP-1]) begin
        mh  = md[DP-1];
        mhv = 1'b1;
      end
      for (int i = DP - 1; i > 0; i--) begin
        md[i] = md[i-1];
        mv[i] = mv[i-1];
      end
      md[0] = d;
      mv[0] = dv;
    end
    if (fl) for (int i = 0; i < DP; i++) mv[i] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] q, input bit qv, input int lvl);
    logic [7:0] nq;
    nq = ~q;
    chk({tag, ".Q"},     32'(bus.Q),     32'(q));
    chk({tag, ".notQ"},  32'(bus.notQ),  32'(nq));
    chk({tag, ".QV"},    32'(bus.QV),    32'(qv));
    chk({tag, ".LEVEL"}, 32'(bus.LEVEL), 32'(lvl));
    chk({tag, ".FULL"},  32'(bus.FULL),  32'(lvl == DP));
    chk({tag, ".EMPTY"}, 32'(bus.EMPTY), 32'(lvl == 0));
  endtask

  task automatic check_hold(input string tag, input logic [7:0] h, input bit hv);
`ifdef D_TRIG_PIPE_HOLD_EN
    chk({tag, ".QH"},  32'(bus.QH),  32'(h));
    chk({tag, ".QHV"}, 32'(bus.QHV), 32'(hv));
`else
    if (h === 8'hxx && hv) $display("unreachable");
`endif
  endtask

  // Inputs are applied just after a sampling point; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit ce, input logic [7:0] d, input bit dv, input bit fl);
    bus.CE    = ce;
    bus.D     = d;
    bus.DV    = dv;
    bus.FLUSH = fl;
    @(posedge C);
    model_edge(ce, d, dv, fl);
    #1;
  endtask

  // Asserts R between edges and checks the outputs before any clock edge arrives.
  task automatic do_reset();
    #2;
    R = 1'b0;
    #1;
    check_all("reset", IV, 1'b0, 0);
    check_hold("reset", IV, 1'b0);
    model_reset();
    @(negedge C);
    R = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         ce;
    logic [7:0] d;
    bit         dv;
    bit         fl;
    logic [7:0] q;
    bit         qv;
    int         lvl;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(bit rst, bit ce, logic [7:0] d, bit dv, bit fl,
                              logic [7:0] q, bit qv, int lvl);
    vec_t v;
    v.rst = rst; v.ce = ce; v.d = d; v.dv = dv; v.fl = fl;
    v.q = q; v.qv = qv; v.lvl = lvl;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    R = 1'b1;
    bus.CE = 1'b0; bus.D = '0; bus.DV = 1'b0; bus.FLUSH = 1'b0;
    model_reset();
    #1;

    //           rst ce d      dv fl   q      qv lvl
    vt.push_back(mk(1, 1, 8'h01, 1, 0, 8'h5A, 0, 1));
    vt.push_back(mk(0, 1, 8'h02, 1, 0, 8'h5A, 0, 2));
    vt.push_back(mk(0, 1, 8'h03, 1, 0, 8'h5A, 0, 3));
    vt.push_back(mk(0, 1, 8'h04, 1, 0, 8'h01, 1, 4));
    vt.push_back(mk(0, 1, 8'h05, 1, 0, 8'h02, 1, 4));
    vt.push_back(mk(0, 1, 8'h06, 1, 0, 8'h03, 1, 4));
    vt.push_back(mk(0, 1, 8'h07, 1, 1, 8'h04, 0, 0));   // flush while full
    vt.push_back(mk(0, 1, 8'h10, 1, 0, 8'h05, 0, 1));   // DV 1,0,1,0,1,0
    vt.push_back(mk(0, 1, 8'h11, 0, 0, 8'h06, 0, 1));
    vt.push_back(mk(0, 1, 8'h12, 1, 0, 8'h07, 0, 2));
    vt.push_back(mk(0, 1, 8'h13, 0, 0, 8'h10, 1, 2));
    vt.push_back(mk(0, 1, 8'h14, 1, 0, 8'h11, 0, 2));
    vt.push_back(mk(0, 1, 8'h15, 0, 0, 8'h12, 1, 2));
    vt.push_back(mk(1, 1, 8'h01, 1, 0, 8'h5A, 0, 1));   // reset with pipe busy, then CE gaps
    vt.push_back(mk(0, 1, 8'h02, 1, 0, 8'h5A, 0, 2));
    vt.push_back(mk(0, 0, 8'h03, 1, 0, 8'h5A, 0, 2));
    vt.push_back(mk(0, 0, 8'h03, 1, 0, 8'h5A, 0, 2));
    vt.push_back(mk(0, 1, 8'h03, 1, 0, 8'h5A, 0, 3));
    vt.push_back(mk(0, 1, 8'h04, 1, 0, 8'h01, 1, 4));
    vt.push_back(mk(0, 1, 8'h05, 0, 0, 8'h02, 1, 3));   // valid out, invalid in
    vt.push_back(mk(0, 0, 8'hFF, 1, 1, 8'h02, 0, 0));   // flush with CE low: data holds

    foreach (vt[k]) begin
      if (vt[k].rst) do_reset();
      step(vt[k].ce, vt[k].d, vt[k].dv, vt[k].fl);
      check_all($sformatf("vec%0d", k), vt[k].q, vt[k].qv, vt[k].lvl);
    end

`ifdef D_TRIG_PIPE_HOLD_EN
    do_reset();
    step(1, 8'hC3, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 0);
    check_hold("hold_cap", 8'hC3, 1'b1);
    step(1, 8'h77, 1, 1);
    check_hold("hold_flush", 8'hC3, 1'b1);
    do_reset();
`endif

    for (int n = 0; n < 600; n++) begin
      bit         ce;
      bit         dv;
      bit         fl;
      logic [7:0] d;
      if (n % 150 == 149) do_reset();
      ce = ($urandom_range(0, 3) != 0);
      dv = $urandom_range(0, 1) == 1;
      fl = ($urandom_range(0, 15) == 0);
      d  = 8'($urandom);
      step(ce, d, dv, fl);
      check_all("rand", md[DP-1], mv[DP-1], model_level());
      check_hold("rand", mh, mhv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
